// File: rtl/wb_cmd_master_pkg.sv
// wb_cmd_master shared definitions.
// FSM encodings and response constants.
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_t;

  // Fill bit for rsp_dat on writes and timeouts.
  localparam logic RSP_FILL = 1'b0;

  function automatic int sel_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master command/response streams
// and Wishbone classic master bus.
interface wb_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import wb_cmd_master_pkg::*;

  localparam int SEL_W = sel_width(DATA_WIDTH);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [SEL_W-1:0]      cmd_sel;
  logic [ADDR_WIDTH-1:0] cmd_adr;
  logic [DATA_WIDTH-1:0] cmd_dat;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_dat;
  logic                  rsp_err;

  logic                  wbm_cyc_o;
  logic                  wbm_stb_o;
  logic                  wbm_we_o;
  logic [SEL_W-1:0]      wbm_sel_o;
  logic [ADDR_WIDTH-1:0] wbm_adr_o;
  logic [DATA_WIDTH-1:0] wbm_dat_o;
  logic                  wbm_ack_i;
  logic [DATA_WIDTH-1:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel,
    input  cmd_adr, cmd_dat, rsp_ready,
    input  wbm_ack_i, wbm_dat_i,
    output cmd_ready, rsp_valid,
    output rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel,
    output cmd_adr, cmd_dat, rsp_ready,
    output wbm_ack_i, wbm_dat_i,
    input  cmd_ready, rsp_valid,
    input  rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// Saturating cycle counter for bus cycles;
// expired flags the last permitted STB cycle.
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  // Count BUS cycles, never wrapping past MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds completed STB cycles, so the
  // current one is the last when cnt==T-1.
  assign expired = enable && (cnt >= LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one
// non-pipelined cycle per command.
module wb_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_cmd_master_if.master bus,
  output logic            busy_o
);
  import wb_cmd_master_pkg::*;

  wb_state_t state;
  logic      accept;
  logic      expired;

  assign accept = (state == IDLE)
               && bus.cmd_valid
               && bus.cmd_ready;

  assign busy_o = (state != IDLE);

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (accept),
    .enable (state == BUS),
    .expired(expired)
  );

  // Command/bus/response FSM, all outputs registered.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      bus.cmd_ready <= 1'b1;
      bus.wbm_cyc_o <= 1'b0;
      bus.wbm_stb_o <= 1'b0;
      bus.wbm_we_o  <= 1'b0;
      bus.wbm_sel_o <= '0;
      bus.wbm_adr_o <= '0;
      bus.wbm_dat_o <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_dat   <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            bus.wbm_we_o  <= bus.cmd_we;
            bus.wbm_sel_o <= bus.cmd_sel;
            bus.wbm_adr_o <= ADDR_WIDTH'(bus.cmd_adr);
            bus.wbm_dat_o <= DATA_WIDTH'(bus.cmd_dat);
            bus.wbm_cyc_o <= 1'b1;
            bus.wbm_stb_o <= 1'b1;
            bus.cmd_ready <= 1'b0;
            state         <= BUS;
          end
        end
        BUS: begin
          // ACK takes priority over expiry.
          if (bus.wbm_ack_i) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_dat   <= bus.wbm_we_o
                           ? {DATA_WIDTH{RSP_FILL}}
                           : bus.wbm_dat_i;
            state         <= RESP;
          end else if (expired) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_dat   <= {DATA_WIDTH{RSP_FILL}};
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master.
// Directed vectors, TIMEOUT_CYCLES=8.
module tb_wb_cmd_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  wb_cmd_master_if #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) bus ();

  wb_cmd_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus),
    .busy_o  (busy)
  );

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int          len;
  } bus_exp_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];

  int checks   = 0;
  int failures = 0;

  int          ack_dly   = 0;
  logic [31:0] slv_rdata = '0;

  function automatic void chk(
    input string      name,
    input logic [71:0] act,
    input logic [71:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endfunction

  // Slave: ACK after ack_dly wait states.
  int scnt = 0;
  always @(negedge clk) begin
    if (bus.wbm_stb_o && !rst) begin
      if (scnt == ack_dly) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = slv_rdata;
      end else begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0BAD_F00D;
      end
      scnt++;
    end else begin
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = 32'h0BAD_F00D;
      scnt = 0;
    end
  end

  // Bus monitor: one entry per STB burst.
  int          blen = 0;
  logic [68:0] bsnap;
  always @(negedge clk) begin
    if (rst) begin
      blen = 0;
    end else if (bus.wbm_stb_o) begin
      chk("cyc_eq_stb", 72'(bus.wbm_cyc_o), 72'd1);
      chk("busy_in_bus", 72'(busy), 72'd1);
      if (blen == 0) begin
        bsnap = {bus.wbm_we_o, bus.wbm_sel_o,
                 bus.wbm_adr_o, bus.wbm_dat_o};
      end else begin
        chk("bus_stable",
            72'({bus.wbm_we_o, bus.wbm_sel_o,
                 bus.wbm_adr_o, bus.wbm_dat_o}),
            72'(bsnap));
      end
      blen++;
    end else if (blen > 0) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 72'(blen), 72'd0);
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        chk("bus_we",  72'(bsnap[68]), 72'(e.we));
        chk("bus_sel", 72'(bsnap[67:64]), 72'(e.sel));
        chk("bus_adr", 72'(bsnap[63:32]), 72'(e.adr));
        if (e.we)
          chk("bus_dat", 72'(bsnap[31:0]), 72'(e.dat));
        chk("stb_len", 72'(blen), 72'(e.len));
      end
      blen = 0;
    end
  end

  // Response monitor: pop on handshake.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 72'd1, 72'd0);
      end else begin
        rsp_exp_t r;
        r = rsp_q.pop_front();
        chk("rsp_dat", 72'(bus.rsp_dat), 72'(r.dat));
        chk("rsp_err", 72'(bus.rsp_err), 72'(r.err));
      end
    end
  end

  task automatic exp_bus(
    input logic we, input logic [3:0] sel,
    input logic [31:0] adr, input logic [31:0] dat,
    input int len
  );
    bus_exp_t e;
    e.we = we; e.sel = sel; e.adr = adr;
    e.dat = dat; e.len = len;
    bus_q.push_back(e);
  endtask

  task automatic exp_rsp(
    input logic [31:0] dat, input logic err
  );
    rsp_exp_t r;
    r.dat = dat; r.err = err;
    rsp_q.push_back(r);
  endtask

  task automatic drive_cmd(
    input logic we, input logic [3:0] sel,
    input logic [31:0] adr, input logic [31:0] dat
  );
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_sel   = sel;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
  endtask

  // Returns #1 after the accepting edge.
  task automatic wait_accept(input string tag);
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready)
      chk({tag, "_accept_timeout"}, 72'd0, 72'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic issue(
    input logic we, input logic [3:0] sel,
    input logic [31:0] adr, input logic [31:0] dat,
    input int dly, input logic [31:0] rd
  );
    ack_dly   = dly;
    slv_rdata = rd;
    @(negedge clk);
    drive_cmd(we, sel, adr, dat);
    wait_accept("issue");
  endtask

  task automatic wait_rsp_valid(input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_seen"}, 72'(bus.rsp_valid), 72'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((bus_q.size() != 0 || rsp_q.size() != 0)
           && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"},
        72'(bus_q.size() + rsp_q.size()), 72'd0);
  endtask

  initial begin
    logic [31:0] held;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_sel   = '0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    bus.rsp_ready = 1'b1;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 72'(bus.cmd_ready), 72'd1);
    chk("rst_cyc_stb",
        72'({bus.wbm_cyc_o, bus.wbm_stb_o}), 72'd0);
    chk("rst_rsp",
        72'({bus.rsp_valid, bus.rsp_err, bus.rsp_dat}),
        72'd0);
    chk("rst_wbm_bus",
        72'({bus.wbm_we_o, bus.wbm_sel_o,
             bus.wbm_adr_o, bus.wbm_dat_o}), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: zero-wait write, latency check.
    exp_bus(1'b1, 4'hF, 32'h3000_0004,
            32'hA5A5_0001, 1);
    exp_rsp(32'h0, 1'b0);
    issue(1'b1, 4'hF, 32'h3000_0004,
          32'hA5A5_0001, 0, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("t1_stb_n1", 72'(bus.wbm_stb_o), 72'd1);
    chk("t1_rsp_n1", 72'(bus.rsp_valid), 72'd0);
    @(negedge clk);
    chk("t1_rsp_n2", 72'(bus.rsp_valid), 72'd1);
    drain("t1");

    // 2: read with 3 wait states.
    exp_bus(1'b0, 4'hF, 32'h3000_0008, 32'h0, 4);
    exp_rsp(32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 4'hF, 32'h3000_0008,
          32'h0, 3, 32'hDEAD_BEEF);
    drain("t2");

    // 3: no ACK, timeout after 8 STB cycles.
    #1 bus.rsp_ready = 1'b0;
    exp_bus(1'b0, 4'h3, 32'h3000_000C, 32'h0, 8);
    exp_rsp(32'h0, 1'b1);
    issue(1'b0, 4'h3, 32'h3000_000C,
          32'h0, -1, 32'h1111_2222);
    wait_rsp_valid("t3");
    @(negedge clk);
    chk("t3_cmd_ready_lo", 72'(bus.cmd_ready), 72'd0);
    chk("t3_stb_lo", 72'(bus.wbm_stb_o), 72'd0);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    drain("t3");

    // 4: ACK coincides with expiry.
    exp_bus(1'b0, 4'hF, 32'h3000_0020, 32'h0, 8);
    exp_rsp(32'h1234_5678, 1'b0);
    issue(1'b0, 4'hF, 32'h3000_0020,
          32'h0, 7, 32'h1234_5678);
    drain("t4");

    // 5: response back-pressure.
    #1 bus.rsp_ready = 1'b0;
    exp_bus(1'b0, 4'hF, 32'h3000_0010, 32'h0, 1);
    exp_rsp(32'hCAFE_0005, 1'b0);
    issue(1'b0, 4'hF, 32'h3000_0010,
          32'h0, 0, 32'hCAFE_0005);
    wait_rsp_valid("t5");
    held = bus.rsp_dat;
    exp_bus(1'b1, 4'hC, 32'h3000_0014,
            32'h5555_AAAA, 1);
    exp_rsp(32'h0, 1'b0);
    ack_dly   = 0;
    slv_rdata = 32'h7777_7777;
    drive_cmd(1'b1, 4'hC, 32'h3000_0014,
              32'h5555_AAAA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", 72'(bus.rsp_valid), 72'd1);
      chk("t5_hold_dat", 72'(bus.rsp_dat), 72'(held));
      chk("t5_hold_ready", 72'(bus.cmd_ready), 72'd0);
      chk("t5_hold_cyc", 72'(bus.wbm_cyc_o), 72'd0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_ready_back", 72'(bus.cmd_ready), 72'd1);
    chk("t5_gap_cyc", 72'(bus.wbm_cyc_o), 72'd0);
    @(negedge clk);
    chk("t5_next_cyc", 72'(bus.wbm_cyc_o), 72'd1);
    bus.cmd_valid = 1'b0;
    drain("t5");

    // 6: reset pulse in the middle of a read.
    issue(1'b0, 4'hF, 32'h3000_0018,
          32'h0, -1, 32'h2222_3333);
    @(negedge clk);
    @(negedge clk);
    chk("t6_stb_pre", 72'(bus.wbm_stb_o), 72'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_drop",
        72'({bus.wbm_cyc_o, bus.wbm_stb_o}), 72'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", 72'(bus.rsp_valid), 72'd0);
    end
    chk("t6_cmd_ready", 72'(bus.cmd_ready), 72'd1);
    chk("t6_busy", 72'(busy), 72'd0);
    exp_bus(1'b1, 4'h1, 32'h3000_001C,
            32'h0000_00C3, 2);
    exp_rsp(32'h0, 1'b0);
    issue(1'b1, 4'h1, 32'h3000_001C,
          32'h0000_00C3, 1, 32'hFFFF_0000);
    drain("t6");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0",
             1);
    $fatal(1, "time limit");
  end

endmodule
